uart_rx_ctrl_fifo: RTL and testbench

- Sits directly downstream of the UART receive datapath. It sequences each frame by driving rx_start and rx_sel, and captures the received byte plus its error status when rx_done rises.
- Buffers received bytes in a first-word-fall-through (FWFT) FIFO and presents them to the LSU read path.
- Provides sticky overrun and frame-error flags, plus a level-sensitive interrupt.

---
 rtl/uart_rx_pkg.sv | 13 +
 rtl/uart_rx_ctrl_fifo_if.sv | 36 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl_fifo.sv | 87 ++++++++
 tb/tb_uart_rx_ctrl_fifo.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive controller and its FWFT buffer.
package uart_rx_pkg;

  localparam int unsigned RX_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {IDLE, START, RECV, STORE} rx_state_t;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_ctrl_fifo_if.sv
// Datapath handshake, LSU read port and status/interrupt signals of the receive controller.
interface uart_rx_ctrl_fifo_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
);
  logic             rx_enable;
  logic             start_detected;
  logic             rx_done;
  logic             data_valid;
  logic [7:0]       data_out;
  logic             rx_start;
  logic             rx_sel;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_err;
  logic             fifo_empty;
  logic             fifo_full;
  logic [PTR_W:0]   rx_level;
  logic             clr_err;
  logic             overrun;
  logic             frame_error;
  logic             irq_en;
  logic             rx_irq;

  modport slave (
    input  rx_enable, start_detected, rx_done, data_valid, data_out, rd_en, clr_err, irq_en,
    output rx_start, rx_sel, rd_data, rd_err, fifo_empty, fifo_full, rx_level, overrun,
           frame_error, rx_irq
  );

  modport master (
    output rx_enable, start_detected, rx_done, data_valid, data_out, rd_en, clr_err, irq_en,
    input  rx_start, rx_sel, rd_data, rd_err, fifo_empty, fifo_full, rx_level, overrun,
           frame_error, rx_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through entry buffer; a full buffer still accepts a push paired with a pop.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = RX_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  rx_entry_t      push_entry,
  input  logic           pop,
  output rx_entry_t      head,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] level,
  output logic           push_ok
);

  localparam logic [PTR_W:0] FullLevel = (PTR_W + 1)'(DEPTH);

  rx_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FullLevel);
  assign level   = level_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/uart_rx_ctrl_fifo.sv
// Frame sequencer for the UART receive datapath, with byte buffering, sticky errors and irq.
module uart_rx_ctrl_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = RX_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                reset,
  uart_rx_ctrl_fifo_if.slave bus
);

  rx_state_t state_q, state_d;
  logic      push, push_ok;
  logic      overrun_q, frame_error_q;
  logic      overrun_set, frame_error_set;
  rx_entry_t push_entry, head;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.rx_start = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.start_detected) state_d = START;
      START: begin
        bus.rx_start = 1'b1;
        state_d      = RECV;
      end
      RECV:  if (bus.rx_done) state_d = STORE;
      STORE: begin
        push    = bus.rx_enable;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A disabled receiver abandons whatever frame is in flight.
    if (!bus.rx_enable) state_d = IDLE;
  end

  assign bus.rx_sel = bus.rx_enable;
  assign push_entry = '{err: ~bus.data_valid, data: bus.data_out};

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (bus.rd_en),
    .head       (head),
    .empty      (bus.fifo_empty),
    .full       (bus.fifo_full),
    .level      (bus.rx_level),
    .push_ok    (push_ok)
  );

  assign bus.rd_data = head.data;
  assign bus.rd_err  = head.err;

  assign overrun_set     = push & ~push_ok;
  assign frame_error_set = push_ok & ~bus.data_valid;

  // A set event in the same cycle as clr_err takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (overrun_set)      overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
      if (frame_error_set)  frame_error_q <= 1'b1;
      else if (bus.clr_err) frame_error_q <= 1'b0;
    end
  end

  assign bus.overrun     = overrun_q;
  assign bus.frame_error = frame_error_q;
  assign bus.rx_irq      = bus.irq_en & (~bus.fifo_empty | overrun_q);

endmodule

// File: tb/tb_uart_rx_ctrl_fifo.sv
// Randomized bench for uart_rx_ctrl_fifo checked against a queue-based model of the buffer.
module tb_uart_rx_ctrl_fifo;
  import uart_rx_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_ctrl_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_ctrl_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  // Model: ordered list of {err, data} entries plus the two sticky flags.
  logic [8:0] m_q[$];
  logic       m_ovr;
  logic       m_fe;

  always @(posedge clk) if (bus.rx_start) start_cnt <= start_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  // Full frame: start, shift, store; optional pop coinciding with the store cycle.
  task automatic send_frame(input logic [7:0] d, input logic v, input logic pop);
    bit pop_ok;
    bus.start_detected = 1'b1;
    cyc();
    bus.start_detected = 1'b0;
    cyc();
    bus.rx_done    = 1'b1;
    bus.data_out   = d;
    bus.data_valid = v;
    cyc();
    bus.rd_en = pop;
    cyc();
    bus.rd_en   = 1'b0;
    bus.rx_done = 1'b0;
    pop_ok = pop && (m_q.size() > 0);
    if (pop_ok) void'(m_q.pop_front());
    if (m_q.size() < DEPTH) begin
      m_q.push_back({~v, d});
      if (!v) m_fe = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic do_pop();
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic do_clr();
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rx_level !== 4'd0) begin errors++;
      $display("FAIL reset_level: got %0d required 0", bus.rx_level); end
    checks++; if ({bus.fifo_empty, bus.fifo_full} !== 2'b10) begin errors++;
      $display("FAIL reset_empty_full: got %b required 10", {bus.fifo_empty, bus.fifo_full}); end
    checks++; if ({bus.overrun, bus.frame_error, bus.rx_irq, bus.rx_start} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b required 0000",
                         {bus.overrun, bus.frame_error, bus.rx_irq, bus.rx_start}); end
    checks++; if ({bus.rd_err, bus.rd_data} !== 9'h000) begin errors++;
      $display("FAIL reset_rd: got %h required 000", {bus.rd_err, bus.rd_data}); end
  endtask

  task automatic test_single_frame();
    int s;
    do_reset();
    s = start_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++; if (start_cnt !== s + 1) begin errors++;
      $display("FAIL single_rx_start_pulses: got %0d required 1", start_cnt - s); end
    checks++; if ({bus.rd_err, bus.rd_data} !== 9'h0A5) begin errors++;
      $display("FAIL single_head: got %h required 0a5", {bus.rd_err, bus.rd_data}); end
    checks++; if (bus.rx_level !== 4'd1 || bus.rx_irq !== 1'b1) begin errors++;
      $display("FAIL single_level_irq: got %0d/%b required 1/1", bus.rx_level, bus.rx_irq); end
    do_pop();
    checks++; if (bus.fifo_empty !== 1'b1 || bus.rx_irq !== 1'b0) begin errors++;
      $display("FAIL single_drain: got empty=%b irq=%b required 1/0", bus.fifo_empty, bus.rx_irq);
    end
  endtask

  task automatic test_bad_frame();
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++; if ({bus.rd_err, bus.rd_data, bus.frame_error} !== 10'h279) begin errors++;
      $display("FAIL bad_entry: got err=%b data=%h fe=%b required 1/3c/1",
               bus.rd_err, bus.rd_data, bus.frame_error); end
    do_clr();
    checks++; if (bus.frame_error !== 1'b0 || bus.rx_level !== 4'd1 || bus.rd_data !== 8'h3C)
    begin errors++; $display("FAIL bad_clr: got fe=%b lvl=%0d data=%h required 0/1/3c",
                             bus.frame_error, bus.rx_level, bus.rd_data); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      if (i == 7) begin
        checks++; if (bus.fifo_full !== 1'b1 || bus.overrun !== 1'b0) begin errors++;
          $display("FAIL ovr_full8: got full=%b ovr=%b required 1/0", bus.fifo_full, bus.overrun);
        end
      end
    end
    checks++; if (bus.overrun !== 1'b1 || bus.rx_level !== 4'd8) begin errors++;
      $display("FAIL ovr_flag: got ovr=%b lvl=%0d required 1/8", bus.overrun, bus.rx_level); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.rd_data !== 8'(i)) begin errors++;
        $display("FAIL ovr_order: got %h required %h", bus.rd_data, 8'(i)); end
      do_pop();
    end
    checks++; if (bus.fifo_empty !== 1'b1 || bus.rx_irq !== 1'b1) begin errors++;
      $display("FAIL ovr_empty_irq: got empty=%b irq=%b required 1/1", bus.fifo_empty, bus.rx_irq);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] last;
    logic [7:0] got;
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    last = 8'($urandom);
    checks++; if (bus.rd_data !== m_q[0][7:0]) begin errors++;
      $display("FAIL fullpop_head: got %h required %h", bus.rd_data, m_q[0][7:0]); end
    send_frame(last, 1'b1, 1'b1);
    checks++; if (bus.overrun !== 1'b0 || bus.rx_level !== 4'd8 || bus.fifo_full !== 1'b1) begin
      errors++; $display("FAIL fullpop_state: got ovr=%b lvl=%0d full=%b required 0/8/1",
                         bus.overrun, bus.rx_level, bus.fifo_full); end
    got = 8'h00;
    while (m_q.size() > 0) begin
      checks++; if ({bus.rd_err, bus.rd_data} !== m_q[0]) begin errors++;
        $display("FAIL fullpop_drain: got %h required %h", {bus.rd_err, bus.rd_data}, m_q[0]); end
      got = bus.rd_data;
      do_pop();
    end
    checks++; if (got !== last) begin errors++;
      $display("FAIL fullpop_last: got %h required %h", got, last); end
  endtask

  task automatic test_abort();
    do_reset();
    send_frame(8'h5A, 1'b1, 1'b0);
    bus.start_detected = 1'b1;
    cyc();
    bus.start_detected = 1'b0;
    cyc();
    bus.rx_enable = 1'b0;
    #1;
    checks++; if (bus.rx_sel !== 1'b0) begin errors++;
      $display("FAIL abort_rx_sel: got %b required 0", bus.rx_sel); end
    cyc();
    bus.rx_done    = 1'b1;
    bus.data_out   = 8'hEE;
    bus.data_valid = 1'b1;
    cyc();
    cyc();
    bus.rx_enable = 1'b1;
    cyc();
    cyc();
    checks++; if (dut.state_q !== IDLE || bus.rx_level !== 4'd1) begin errors++;
      $display("FAIL abort_no_push: got state=%0d lvl=%0d required 0/1",
               dut.state_q, bus.rx_level); end
    bus.rx_done = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    bus.start_detected = 1'b1;
    cyc();
    bus.start_detected = 1'b0;
    cyc();
    do_reset();
    checks++; if (bus.rx_level !== 4'd0 || bus.frame_error !== 1'b0 || bus.overrun !== 1'b0 ||
                  bus.fifo_empty !== 1'b1 || dut.state_q !== IDLE) begin errors++;
      $display("FAIL midreset: got lvl=%0d fe=%b ovr=%b empty=%b required 0/0/0/1",
               bus.rx_level, bus.frame_error, bus.overrun, bus.fifo_empty); end
    do_pop();
    do_pop();
    checks++; if (bus.rx_level !== 4'd0 || bus.fifo_empty !== 1'b1) begin errors++;
      $display("FAIL underflow: got lvl=%0d empty=%b required 0/1", bus.rx_level, bus.fifo_empty);
    end
  endtask

  task automatic test_random();
    int op;
    logic [3:0] exp_lvl;
    logic [8:0] exp_head;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      bus.irq_en = 1'($urandom_range(0, 3) != 0);
      exp_head = (m_q.size() > 0) ? m_q[0] : 9'h000;
      checks++; if ({bus.rd_err, bus.rd_data} !== exp_head) begin errors++;
        $display("FAIL rand_head[%0d]: got %h required %h", n, {bus.rd_err, bus.rd_data}, exp_head);
      end
      if (op < 6) send_frame(8'($urandom), 1'($urandom_range(0, 3) != 0),
                             1'($urandom_range(0, 2) == 0));
      else if (op < 9) do_pop();
      else do_clr();
      exp_lvl = 4'(m_q.size());
      checks++;
      if (bus.rx_level !== exp_lvl || bus.fifo_empty !== (exp_lvl == 0) ||
          bus.fifo_full !== (exp_lvl == 4'(DEPTH)) || bus.overrun !== m_ovr ||
          bus.frame_error !== m_fe || bus.rx_irq !== (bus.irq_en & ((exp_lvl != 0) | m_ovr)))
      begin
        errors++;
        $display("FAIL rand_state[%0d]: got lvl=%0d e=%b f=%b ovr=%b fe=%b irq=%b required lvl=%0d ovr=%b fe=%b",
                 n, bus.rx_level, bus.fifo_empty, bus.fifo_full, bus.overrun, bus.frame_error,
                 bus.rx_irq, exp_lvl, m_ovr, m_fe);
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.rx_enable      = 1'b1;
    bus.start_detected = 1'b0;
    bus.rx_done        = 1'b0;
    bus.data_valid     = 1'b1;
    bus.data_out       = 8'h00;
    bus.rd_en          = 1'b0;
    bus.clr_err        = 1'b0;
    bus.irq_en         = 1'b1;
    m_ovr              = 1'b0;
    m_fe               = 1'b0;
    cyc();
    test_reset();
    test_single_frame();
    test_bad_frame();
    test_overrun();
    test_full_pop();
    test_abort();
    test_reset_mid_frame();
    bus.irq_en = 1'b1;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
